// File: rtl/game_pkg.sv
// Shared game constants: cat bounding box, projectile state encoding,
// fixed-point format and the video bundle carried between draw stages.
package game_pkg;

    // Cat bounding box, shared with the cat draw stage.
    localparam int TARGET_X = 1;
    localparam int TARGET_Y = 430;
    localparam int TARGET_W = 157;
    localparam int TARGET_H = 99;

    // Fractional bits of the Q12.4 vertical position.
    localparam int Q_FRAC = 4;

    typedef enum logic [1:0] {
        PS_IDLE  = 2'd0,
        PS_FLY   = 2'd1,
        PS_CHECK = 2'd2,
        PS_HIT   = 2'd3
    } proj_state_t;

    // One registered copy of the video stream.
    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

    // True when half-open intervals [a_lo,a_hi) and [b_lo,b_hi) intersect.
    function automatic logic spans_overlap(
        input logic signed [12:0] a_lo,
        input logic signed [12:0] a_hi,
        input logic signed [12:0] b_lo,
        input logic signed [12:0] b_hi
    );
        return (a_lo < b_hi) && (a_hi > b_lo);
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA pixel stream bundle passed between draw stages.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/projectile_physics.sv
// Projectile state machine and kinematics: launch, once-per-frame motion,
// hit/miss decision against the cat box, hit pulse and busy flag.
module projectile_physics
    import game_pkg::*;
#(
    parameter int START_X  = 860,
    parameter int START_Y  = 400,
    parameter int VX       = 8,
    parameter int SIZE     = 16,
    parameter int GROUND_Y = 600
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               fire,
    input  logic [6:0]         power,
    output logic signed [11:0] x,
    output logic signed [11:0] yi,
    output logic               busy,
    output logic               hit_cat
);

    localparam logic signed [12:0] BOX_L  = 13'(TARGET_X);
    localparam logic signed [12:0] BOX_R  = 13'(TARGET_X + TARGET_W);
    localparam logic signed [12:0] BOX_T  = 13'(TARGET_Y);
    localparam logic signed [12:0] BOX_B  = 13'(TARGET_Y + TARGET_H);
    localparam logic signed [12:0] GROUND = 13'(GROUND_Y);
    localparam logic signed [12:0] SIDE   = 13'(SIZE);

    proj_state_t        state_q, state_d;
    logic signed [11:0] x_q, x_d;
    logic signed [15:0] y_q, y_d;
    logic signed [11:0] vy_q, vy_d;
    logic               busy_q, busy_d;
    logic               hit_q, hit_d;

    logic signed [12:0] x_ext_s;
    logic signed [12:0] yi_ext_s;
    logic               hit_s;
    logic               miss_s;

    // Hit/miss evaluation on the freshly updated position (whole pixels).
    always_comb begin
        x_ext_s  = {x_q[11], x_q};
        yi_ext_s = {y_q[15], y_q[15:Q_FRAC]};
        hit_s    = spans_overlap(x_ext_s, x_ext_s + SIDE, BOX_L, BOX_R) &&
                   spans_overlap(yi_ext_s, yi_ext_s + SIDE, BOX_T, BOX_B);
        miss_s   = (yi_ext_s >= GROUND) || ((x_ext_s + SIDE) <= 13'sd0);
    end

    // Next-state and kinematics: one motion step per frame tick while flying.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vy_d    = vy_q;
        case (state_q)
            PS_IDLE: begin
                if (fire) begin
                    x_d     = 12'(START_X);
                    y_d     = 16'(START_Y * (1 << Q_FRAC));
                    vy_d    = 12'sd0 - $signed({5'd0, power});
                    state_d = PS_FLY;
                end else begin
                    state_d = PS_IDLE;
                end
            end
            PS_FLY: begin
                if (tick) begin
                    x_d     = x_q - 12'(VX);
                    y_d     = y_q + {{4{vy_q[11]}}, vy_q};
                    vy_d    = vy_q + 12'sd1;
                    state_d = PS_CHECK;
                end else begin
                    state_d = PS_FLY;
                end
            end
            PS_CHECK: begin
                if (hit_s) begin
                    state_d = PS_HIT;
                end else if (miss_s) begin
                    state_d = PS_IDLE;
                end else begin
                    state_d = PS_FLY;
                end
            end
            PS_HIT: begin
                state_d = PS_IDLE;
            end
            default: begin
                state_d = PS_IDLE;
            end
        endcase
        busy_d = (state_d != PS_IDLE);
        hit_d  = (state_d == PS_HIT);
    end

    // State, kinematic and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PS_IDLE;
            x_q     <= 12'sd0;
            y_q     <= 16'sd0;
            vy_q    <= 12'sd0;
            busy_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vy_q    <= vy_d;
            busy_q  <= busy_d;
            hit_q   <= hit_d;
        end
    end

    assign x       = x_q;
    assign yi      = y_q[15:Q_FRAC];
    assign busy    = busy_q;
    assign hit_cat = hit_q;

endmodule

// File: rtl/draw_projectile.sv
// Dog-side projectile draw stage: delays the video stream one cycle,
// derives the frame tick and overlays the projectile square.
module draw_projectile
    import game_pkg::*;
#(
    parameter int          START_X  = 860,
    parameter int          START_Y  = 400,
    parameter int          VX       = 8,
    parameter int          SIZE     = 16,
    parameter int          GROUND_Y = 600,
    parameter logic [11:0] PROJ_RGB = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fire,
    input  logic [6:0]  power,
    output logic        hit_cat,
    output logic        busy,
    vga_if.vga_in       vga_in,
    vga_if.vga_out      vga_out
);

    localparam logic signed [12:0] SIDE = 13'(SIZE);

    vga_t               vid_q, vid_d;
    logic               vblnk_prev_q, vblnk_prev_d;
    logic               tick_s;
    logic signed [11:0] proj_x_s;
    logic signed [11:0] proj_yi_s;
    logic signed [12:0] dx_s;
    logic signed [12:0] dy_s;
    logic               inside_s;
    logic [11:0]        rgb_s;

    // Capture the incoming stream and the previous registered vblnk.
    always_comb begin
        vid_d.hcount = vga_in.hcount;
        vid_d.vcount = vga_in.vcount;
        vid_d.hsync  = vga_in.hsync;
        vid_d.vsync  = vga_in.vsync;
        vid_d.hblnk  = vga_in.hblnk;
        vid_d.vblnk  = vga_in.vblnk;
        vid_d.rgb    = vga_in.rgb;
        vblnk_prev_d = vid_q.vblnk;
    end

    // One-cycle video delay plus vblnk history for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_q        <= '0;
            vblnk_prev_q <= 1'b0;
        end else begin
            vid_q        <= vid_d;
            vblnk_prev_q <= vblnk_prev_d;
        end
    end

    assign tick_s = vid_q.vblnk & ~vblnk_prev_q;

    projectile_physics #(
        .START_X  (START_X),
        .START_Y  (START_Y),
        .VX       (VX),
        .SIZE     (SIZE),
        .GROUND_Y (GROUND_Y)
    ) u_physics (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick_s),
        .fire    (fire),
        .power   (power),
        .x       (proj_x_s),
        .yi      (proj_yi_s),
        .busy    (busy),
        .hit_cat (hit_cat)
    );

    // Overlay the projectile on visible pixels of the delayed stream.
    always_comb begin
        dx_s     = $signed({2'b00, vid_q.hcount}) - $signed({proj_x_s[11], proj_x_s});
        dy_s     = $signed({2'b00, vid_q.vcount}) - $signed({proj_yi_s[11], proj_yi_s});
        inside_s = busy && !vid_q.hblnk && !vid_q.vblnk &&
                   (dx_s >= 13'sd0) && (dx_s < SIDE) &&
                   (dy_s >= 13'sd0) && (dy_s < SIDE);
        if (inside_s) begin
            rgb_s = PROJ_RGB;
        end else begin
            rgb_s = vid_q.rgb;
        end
    end

    assign vga_out.hcount = vid_q.hcount;
    assign vga_out.vcount = vid_q.vcount;
    assign vga_out.hsync  = vid_q.hsync;
    assign vga_out.vsync  = vid_q.vsync;
    assign vga_out.hblnk  = vid_q.hblnk;
    assign vga_out.vblnk  = vid_q.vblnk;
    assign vga_out.rgb    = rgb_s;

endmodule

// File: tb/tb_draw_projectile.sv
// Randomized bench for draw_projectile against a closed-form trajectory model.
module tb_draw_projectile;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fire = 1'b0;
    logic [6:0] power = 7'd0;
    logic       hit_cat;
    logic       busy;

    vga_if vin ();
    vga_if vout ();

    draw_projectile dut (
        .clk     (clk),
        .rst     (rst),
        .fire    (fire),
        .power   (power),
        .hit_cat (hit_cat),
        .busy    (busy),
        .vga_in  (vin),
        .vga_out (vout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int floor16(input int v);
        return (v >= 0) ? (v / 16) : -((-v + 15) / 16);
    endfunction
    function automatic int px(input int n);
        return 860 - 8 * n;
    endfunction
    function automatic int py(input int p, input int n);
        return 400 * 16 - p * n + (n * (n - 1)) / 2;   // Q12.4 after n frames
    endfunction

    // Frame count at which the flight ends and whether it ends in a hit.
    task automatic plan(input int p, output int nend, output int hit);
        nend = 0;
        hit  = 0;
        for (int n = 1; n < 1000; n++) begin
            int x, yi;
            x  = px(n);
            yi = floor16(py(p, n));
            if (x < 158 && x + 16 > 1 && yi < 529 && yi + 16 > 430) begin
                nend = n; hit = 1; return;
            end
            if (yi >= 600 || x + 16 <= 0) begin
                nend = n; hit = 0; return;
            end
        end
    endtask

    int m_active = 0, m_n = 0, m_tail = 0, m_hitout = 0, m_nend = 0, m_power = 0;
    int m_hit_exp = 0;
    int r_vb = 0, r_vbp = 0;        // registered vblnk and its previous value
    int obs_hits = 0;

    int fr_pos = 0, fr_len = 8, fr_vb = 3;
    int d_hc, d_vc, d_hs, d_vs, d_hb, d_vb, d_rgb;

    task automatic drive_vga(input int vb_v);
        int sel, cx, cy;
        sel = int'($urandom_range(0, 7));
        cx  = px(m_n);
        cy  = floor16(py(m_power, m_n));
        if (m_active != 0 && sel == 0) begin
            d_hc = cx; d_vc = cy;
        end else if (m_active != 0 && sel == 1) begin
            d_hc = cx + 16; d_vc = cy;
        end else if (m_active != 0 && sel < 6) begin
            d_hc = cx + int'($urandom_range(0, 23)) - 4;
            d_vc = cy + int'($urandom_range(0, 23)) - 4;
        end else begin
            d_hc = int'($urandom_range(0, 2047));
            d_vc = int'($urandom_range(0, 2047));
        end
        d_hc  = d_hc & 2047;
        d_vc  = d_vc & 2047;
        d_hs  = int'($urandom_range(0, 1));
        d_vs  = int'($urandom_range(0, 1));
        d_hb  = ($urandom_range(0, 5) == 0) ? 1 : 0;
        d_vb  = vb_v;
        d_rgb = int'($urandom_range(0, 4095));
        vin.hcount = d_hc[10:0];
        vin.vcount = d_vc[10:0];
        vin.hsync  = d_hs[0];
        vin.vsync  = d_vs[0];
        vin.hblnk  = d_hb[0];
        vin.vblnk  = d_vb[0];
        vin.rgb    = d_rgb[11:0];
    endtask

    function automatic int exp_rgb();
        int cx, cy, dx, dy;
        cx = px(m_n);
        cy = floor16(py(m_power, m_n));
        dx = d_hc - cx;
        dy = d_vc - cy;
        if (m_active != 0 && d_hb == 0 && d_vb == 0 &&
            dx >= 0 && dx < 16 && dy >= 0 && dy < 16)
            return 4095;
        return d_rgb;
    endfunction

    // One clock: drive at negedge, model at posedge, check at next negedge.
    task automatic cycle(input int fire_v);
        int vb_v, tick_c;
        vb_v = (fr_pos < fr_vb) ? 1 : 0;
        fr_pos++;
        if (fr_pos >= fr_len) begin
            fr_pos = 0;
            fr_len = int'($urandom_range(6, 12));
            fr_vb  = int'($urandom_range(2, 4));
        end
        fire = (fire_v != 0);
        drive_vga(vb_v);
        tick_c = (r_vb != 0 && r_vbp == 0) ? 1 : 0;
        @(posedge clk);
        r_vbp = r_vb;
        r_vb  = vb_v;
        m_hit_exp = 0;
        if (m_active == 0) begin
            if (fire_v != 0) begin
                m_active = 1; m_n = 0; m_tail = 0; m_power = int'(power);
                plan(m_power, m_nend, m_hitout);
            end
        end else if (m_tail == 0) begin
            if (tick_c != 0) begin
                m_n++;
                if (m_n == m_nend) m_tail = (m_hitout != 0) ? 2 : 1;
            end
        end else begin
            m_tail--;
            if (m_tail == 1) m_hit_exp = 1;
            if (m_tail == 0) m_active = 0;
        end
        @(negedge clk);
        chk("busy", busy, m_active);
        chk("hit_cat", hit_cat, m_hit_exp);
        chk("rgb", vout.rgb, exp_rgb());
        chk("vga_delay",
            {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk},
            {d_hc[10:0], d_vc[10:0], d_hs[0], d_vs[0], d_hb[0], d_vb[0]});
        if (m_active != 0) begin
            chk("pos_x", dut.proj_x_s, px(m_n));
            chk("pos_yi", dut.proj_yi_s, floor16(py(m_power, m_n)));
        end
        if (hit_cat === 1'b1) obs_hits++;
    endtask

    task automatic check_zero_out(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_hit"}, hit_cat, 0);
        chk({tag, "_vga"},
            {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb}, 0);
    endtask

    task automatic reset_dut();
        m_active = 0; m_hit_exp = 0; m_tail = 0;
        r_vb = 0; r_vbp = 0;
        fire = 1'b0;
        drive_vga(1);
        rst = 1'b1;
        #1;
        check_zero_out("rst_now");
        @(posedge clk);
        @(negedge clk);
        check_zero_out("rst_held");
        rst = 1'b0;
    endtask

    task automatic launch(input int p, input int on_tick);
        int guard;
        power = 7'(p);
        obs_hits = 0;
        guard = 0;
        if (on_tick != 0) begin
            while (!(r_vb != 0 && r_vbp == 0) && guard < 50) begin
                cycle(0); guard++;
            end
        end
        cycle(1);
    endtask

    // Fly until the model says idle (or stop_at frames), with stray fire pulses.
    task automatic fly(input int stop_at);
        int guard;
        guard = 0;
        while (m_active != 0 && !(stop_at > 0 && m_n >= stop_at) && guard < 4000) begin
            cycle(($urandom_range(0, 9) == 0) ? 1 : 0);
            guard++;
        end
        if (stop_at == 0) chk("shot_ended_busy", busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        drive_vga(0);
        @(negedge clk);
        reset_dut();
        for (int i = 0; i < 12; i++) cycle(0);

        // Hit at frame 88.
        launch(30, 0);
        fly(0);
        chk("p30_hits", obs_hits, 1);
        chk("p30_end_x", dut.proj_x_s, 156);
        chk("p30_end_yi", dut.proj_yi_s, 474);

        // Ground miss, launched in the same cycle as a tick.
        launch(0, 1);
        fly(0);
        chk("p0_hits", obs_hits, 0);
        chk("p0_end_x", dut.proj_x_s, 212);
        chk("p0_end_yi", dut.proj_yi_s, 602);

        // Passes over the box, leaves the left edge.
        launch(127, 0);
        fly(0);
        chk("p127_hits", obs_hits, 0);
        chk("p127_end_x", dut.proj_x_s, -20);
        chk("p127_end_yi", dut.proj_yi_s, -99);

        // Reset mid-flight, then relaunch.
        launch(30, 0);
        fly(40);
        reset_dut();
        chk("rst_mid_hits", obs_hits, 0);
        for (int i = 0; i < 5; i++) cycle(0);
        launch(30, 0);
        chk("relaunch_x", dut.proj_x_s, 860);
        chk("relaunch_yi", dut.proj_yi_s, 400);
        fly(0);
        chk("relaunch_hits", obs_hits, 1);

        // Random strengths.
        for (int k = 0; k < 6; k++) begin
            int gap;
            gap = int'($urandom_range(0, 7));
            for (int i = 0; i < gap; i++) cycle(0);
            launch(int'($urandom_range(0, 127)), int'($urandom_range(0, 1)));
            fly(0);
            chk("rand_hits", obs_hits, m_hitout);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
